// File: rtl/vert_ucode_seq.sv
// Vertical-microcode sequencer: fetches from a 1-cycle ROM, runs control ops locally,
// hands datapath ops off over vld/rdy, and keeps return addresses on a small hardware stack.
module vert_ucode_seq #(
   parameter int PC_W    = 8,
   parameter int INST_W  = 16,
   parameter int STACK_N = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [PC_W-1:0]   i_start_pc,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_inst_req,
   output logic [PC_W-1:0]   o_inst_addr,
   input  logic [INST_W-1:0] i_inst_rdata,
   input  logic              i_flag_eq,
   input  logic              i_flag_gt,
   output logic              o_dp_vld,
   output logic [INST_W-1:0] o_dp_inst,
   input  logic              i_dp_rdy,
   input  logic              i_go,
   output logic              o_emit,
   output logic              o_error,
   output logic [1:0]        o_err_code,
   output logic [2:0]        o_dbg_state
);

   localparam int SP_W  = $clog2(STACK_N + 1);
   localparam int IDX_W = (STACK_N > 1) ? $clog2(STACK_N) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_N);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   // Datapath handshake: o_dp_vld rises in EXEC of a datapath op and stays high,
   // with o_dp_inst frozen, until the cycle i_dp_rdy is seen; that cycle is the transfer.

   logic [2:0]        r_state;
   logic [PC_W-1:0]   r_pc;
   logic [SP_W-1:0]   r_sp;
   logic [INST_W-1:0] r_ir;
   logic              r_done;
   logic              r_error;
   logic [1:0]        r_err_code;
   logic [PC_W-1:0]   r_stack [STACK_N];

   logic [2:0]        w_state_nxt;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [PC_W-1:0]   w_pc_inc;
   logic [PC_W-1:0]   w_target;
   logic [SP_W-1:0]   w_sp_dec;
   logic [IDX_W-1:0]  w_push_idx;
   logic [IDX_W-1:0]  w_pop_idx;
   logic [3:0]        w_opcode;
   logic              w_start_acc;
   logic              w_push;
   logic              w_pop;
   logic              w_set_err;
   logic [1:0]        w_err_code_nxt;
   logic              w_done_nxt;
   logic              w_emit;
   logic              w_dp_vld;
   logic              w_taken;

   assign w_pc_inc   = r_pc + 1'b1;
   assign w_target   = PC_W'(r_ir[7:0]);
   assign w_sp_dec   = r_sp - 1'b1;
   assign w_push_idx = r_sp[IDX_W-1:0];
   assign w_pop_idx  = w_sp_dec[IDX_W-1:0];
   assign w_opcode   = r_ir[15:12];

   always_comb begin
      w_taken = 1'b0;
      case (r_ir[9:8])
         2'b00:   w_taken = 1'b1;
         2'b01:   w_taken = i_flag_eq;
         2'b10:   w_taken = i_flag_gt;
         default: w_taken = ~i_flag_gt;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_start_acc    = 1'b0;
      w_push         = 1'b0;
      w_pop          = 1'b0;
      w_set_err      = 1'b0;
      w_err_code_nxt = 2'd0;
      w_done_nxt     = 1'b0;
      w_emit         = 1'b0;
      w_dp_vld       = 1'b0;
      case (r_state)
         S_IDLE, S_ERROR: begin
            if (i_start) begin
               w_start_acc = 1'b1;
               w_pc_nxt    = i_start_pc;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC: begin
            case (w_opcode)
               4'b0000: begin
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = S_FETCH;
               end
               4'b0001: begin
                  w_pc_nxt    = w_taken ? w_target : w_pc_inc;
                  w_state_nxt = S_FETCH;
               end
               4'b0010, 4'b0100, 4'b0110, 4'b0111: begin
                  w_dp_vld = 1'b1;
                  if (i_dp_rdy) begin
                     w_pc_nxt    = w_pc_inc;
                     w_state_nxt = S_FETCH;
                  end
               end
               4'b1100: begin
                  if (r_ir[11]) begin
                     if (r_sp == SP_FULL) begin
                        w_set_err      = 1'b1;
                        w_err_code_nxt = 2'd1;
                        w_state_nxt    = S_ERROR;
                     end else begin
                        w_push      = 1'b1;
                        w_pc_nxt    = w_target;
                        w_state_nxt = S_FETCH;
                     end
                  end else if (r_sp == '0) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_pop       = 1'b1;
                     w_pc_nxt    = r_stack[w_pop_idx];
                     w_state_nxt = S_FETCH;
                  end
               end
               4'b1111: begin
                  if (r_ir[11]) begin
                     w_state_nxt = S_WAIT;
                  end else begin
                     w_emit      = 1'b1;
                     w_pc_nxt    = w_pc_inc;
                     w_state_nxt = S_FETCH;
                  end
               end
               default: begin
                  w_set_err      = 1'b1;
                  w_err_code_nxt = 2'd2;
                  w_state_nxt    = S_ERROR;
               end
            endcase
         end
         S_WAIT: begin
            if (i_go) begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_sp       <= '0;
         r_ir       <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_done  <= w_done_nxt;
         if (r_state == S_DECODE) r_ir <= i_inst_rdata;
         if (w_start_acc) begin
            r_sp       <= '0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
         end else if (w_push) begin
            r_sp <= r_sp + 1'b1;
         end else if (w_pop) begin
            r_sp <= w_sp_dec;
         end
         if (w_set_err) begin
            r_error    <= 1'b1;
            r_err_code <= w_err_code_nxt;
         end
      end
   end

   // Stack storage needs no reset: entries are only read below sp, which reset clears.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_push) r_stack[w_push_idx] <= w_pc_inc;
   end

   assign o_busy      = (r_state != S_IDLE) && (r_state != S_ERROR);
   assign o_done      = r_done;
   assign o_inst_req  = (r_state == S_FETCH);
   assign o_inst_addr = r_pc;
   assign o_dp_vld    = w_dp_vld;
   assign o_dp_inst   = w_dp_vld ? r_ir : '0;
   assign o_emit      = w_emit;
   assign o_error     = r_error;
   assign o_err_code  = r_err_code;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vert_ucode_seq.sv
// Directed bench for vert_ucode_seq: a small ROM model answers fetches one cycle later,
// each scenario's fetch trace, done timing and error status are checked against hand-derived values.
module tb_vert_ucode_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  start_pc = 8'h00;
   logic        busy, done, inst_req, dp_vld, emit, error;
   logic [7:0]  inst_addr;
   logic [15:0] inst_rdata = 16'h0000;
   logic        flag_eq = 1'b0;
   logic        flag_gt = 1'b0;
   logic [15:0] dp_inst;
   logic        dp_rdy = 1'b0;
   logic        go = 1'b0;
   logic [1:0]  err_code;
   logic [2:0]  dbg_state;

   logic [15:0] rom [256];
   logic [7:0]  act_q [$];
   logic [7:0]  exp_q [$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          emit_cnt;
   int          done_cyc;
   logic        dp_seen;

   vert_ucode_seq dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_pc(start_pc),
      .o_busy(busy), .o_done(done), .o_inst_req(inst_req), .o_inst_addr(inst_addr),
      .i_inst_rdata(inst_rdata), .i_flag_eq(flag_eq), .i_flag_gt(flag_gt),
      .o_dp_vld(dp_vld), .o_dp_inst(dp_inst), .i_dp_rdy(dp_rdy), .i_go(go),
      .o_emit(emit), .o_error(error), .o_err_code(err_code), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (inst_req) inst_rdata <= rom[inst_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_trace(input string tag);
      check({tag, "_len"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         check({tag, "_addr"}, act_q[i], exp_q[i]);
   endtask

   // Pulse start, then watch until the sequencer leaves busy; cycle 1 is the first FETCH.
   task automatic run_prog(input logic [7:0] spc);
      int k;
      act_q.delete();
      emit_cnt = 0;
      done_cyc = -1;
      dp_seen  = 1'b0;
      @(negedge clk);
      start_pc = spc;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (k = 1; k <= 400; k++) begin
         if (inst_req) act_q.push_back(inst_addr);
         if (emit) emit_cnt++;
         if (dp_vld) dp_seen = 1'b1;
         if (done && done_cyc < 0) done_cyc = k;
         if (!busy) break;
         @(negedge clk);
      end
      check("run_terminates", busy, 1'b0);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && busy; k++) @(negedge clk);
      check("wait_idle", busy, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h3000;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_req", inst_req, 0);
      check("rst_addr", inst_addr, 0);
      check("rst_dp_vld", dp_vld, 0);
      check("rst_error", error, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_state", dbg_state, 3'd0);

      // branch: JCC EQ taken to 5, RET
      rom[8'h00] = 16'h1105;
      rom[8'h05] = 16'hC000;
      flag_eq = 1'b1;
      run_prog(8'h00);
      exp_q = '{8'h00, 8'h05};
      check_trace("branch");
      check("branch_done_cyc", done_cyc, 7);
      @(negedge clk);
      check("branch_done_pulse", done, 0);
      flag_eq = 1'b0;

      // GT not taken, then LE taken (gt=0)
      rom[8'hE8] = 16'h1205;
      rom[8'hE9] = 16'h1305;
      run_prog(8'hE8);
      exp_q = '{8'hE8, 8'hE9, 8'h05};
      check_trace("jcc_gt_le");
      check("jcc_done_cyc", done_cyc, 10);

      // nested calls four deep
      rom[8'h10] = 16'hC820; rom[8'h11] = 16'hC000;
      rom[8'h20] = 16'hC830; rom[8'h21] = 16'hC000;
      rom[8'h30] = 16'hC840; rom[8'h31] = 16'hC000;
      rom[8'h40] = 16'hC850; rom[8'h41] = 16'hC000;
      rom[8'h50] = 16'hC000;
      run_prog(8'h10);
      exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h41, 8'h31, 8'h21, 8'h11};
      check_trace("nest");
      check("nest_done_cyc", done_cyc, 28);
      check("nest_error", error, 0);

      // overflow on fifth CALL
      rom[8'h60] = 16'hC870; rom[8'h70] = 16'hC880; rom[8'h80] = 16'hC890;
      rom[8'h90] = 16'hC8A0; rom[8'hA0] = 16'hC8B0;
      run_prog(8'h60);
      exp_q = '{8'h60, 8'h70, 8'h80, 8'h90, 8'hA0};
      check_trace("ovf");
      check("ovf_done_cyc", done_cyc, -1);
      check("ovf_error", error, 1);
      check("ovf_code", err_code, 2'd1);
      check("ovf_busy", busy, 0);
      check("ovf_state", dbg_state, 3'd5);
      repeat (3) @(negedge clk);
      check("ovf_sticky", error, 1);
      rom[8'hB0] = 16'hC000;
      run_prog(8'hB0);
      check("restart_done_cyc", done_cyc, 4);
      check("restart_error", error, 0);
      check("restart_code", err_code, 2'd0);

      // datapath stall: rdy low for 3 EXEC cycles
      rom[8'hC0] = 16'h6ABC;
      rom[8'hC1] = 16'hC000;
      @(negedge clk);
      start_pc = 8'hC0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("stall_vld", dp_vld, 1);
         check("stall_inst", dp_inst, 16'h6ABC);
         check("stall_pc", inst_addr, 8'hC0);
         if (k == 3) dp_rdy = 1'b1;
         if (k < 3) @(negedge clk);
      end
      @(negedge clk);
      dp_rdy = 1'b0;
      check("stall_vld_drop", dp_vld, 0);
      check("stall_next_req", inst_req, 1);
      check("stall_next_addr", inst_addr, 8'hC1);
      wait_idle();

      // EMIT, WAIT, EMIT, RET with go ignored in FETCH; go beats start in WAIT
      rom[8'hD0] = 16'hF000; rom[8'hD1] = 16'hF800;
      rom[8'hD2] = 16'hF000; rom[8'hD3] = 16'hC000;
      @(negedge clk);
      start_pc = 8'hD0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; go = 1'b1;
      check("we_fetch", dbg_state, 3'd1);
      @(negedge clk);
      go = 1'b0;
      check("we_go_ignored", dbg_state, 3'd2);
      @(negedge clk);
      check("we_emit1", emit, 1);
      @(negedge clk);
      check("we_emit1_pulse", emit, 0);
      check("we_addr_wait", inst_addr, 8'hD1);
      repeat (3) @(negedge clk);
      repeat (9) @(negedge clk);
      check("we_in_wait", dbg_state, 3'd4);
      check("we_wait_busy", busy, 1);
      start_pc = 8'h00; start = 1'b1; go = 1'b1;
      @(negedge clk);
      start = 1'b0; go = 1'b0;
      check("we_resume_state", dbg_state, 3'd1);
      check("we_resume_addr", inst_addr, 8'hD2);
      repeat (2) @(negedge clk);
      check("we_emit2", emit, 1);
      wait_idle();

      // pc wrap 0xFF -> 0x00
      rom[8'hFF] = 16'h0000;
      rom[8'h00] = 16'hC000;
      run_prog(8'hFF);
      exp_q = '{8'hFF, 8'h00};
      check_trace("wrap");
      check("wrap_done_cyc", done_cyc, 7);

      // invalid opcode 0011
      rom[8'hE0] = 16'h3000;
      run_prog(8'hE0);
      check("inv_error", error, 1);
      check("inv_code", err_code, 2'd2);
      check("inv_busy", busy, 0);
      check("inv_no_dp", dp_seen, 0);

      // reset while a datapath op is stalled in EXEC
      @(negedge clk);
      start_pc = 8'hC0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("rexec_vld", dp_vld, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rexec_busy", busy, 0);
      check("rexec_req", inst_req, 0);
      check("rexec_addr", inst_addr, 0);
      check("rexec_dp", {dp_vld, dp_inst}, 0);
      check("rexec_misc", {done, emit, error, err_code}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
